// File: rtl/regfile_wr_decoder.sv
// -----------------------------------------------------------------------------
// regfile_wr_decoder
//   Write-enable decoder for the 32-entry register file (write-back stage).
//   A 2:4 stage, enabled by RegWrite and selected by addr[4:3], enables one of
//   four 3:8 stages, each selected by addr[2:0]. The result is a one-hot
//   32-bit write-enable vector that is all-zero when RegWrite is low.
//
// Parameters
//   OUT_REG  1 = wr_en/grp_en registered (1-cycle latency), 0 = combinational
//
// Ports
//   clk       in   1   clock, rising edge (unused when OUT_REG = 0)
//   reset_n   in   1   asynchronous active-low reset (unused when OUT_REG = 0)
//   RegWrite  in   1   write request; gates the whole decode tree
//   addr      in   5   destination register number 0..31
//   wr_en     out  32  one-hot write enable, wr_en[k] = write register k
//   grp_en    out  4   2:4 stage output, grp_en[g] = registers 8g..8g+7
//
// Configuration macro
//   XZR_MASK_EN  when defined, addr = 31 (XZR) never raises a write enable;
//                grp_en[3] still asserts, so the 2:4 stage is unchanged.
// -----------------------------------------------------------------------------

// One 3:8 leaf of the tree. The enable gates every output, so an unknown
// select cannot leak through while the leaf is disabled.
module regfile_wr_dec3to8 (
    input  logic       en_i,
    input  logic [2:0] sel_i,
    output logic [7:0] dec_o
);
    always_comb begin
        dec_o = 8'h00;
        if (en_i) begin
            for (int j = 0; j < 8; j++) begin
                dec_o[j] = (sel_i == 3'(j));
            end
        end
    end
endmodule

module regfile_wr_decoder #(
    parameter bit OUT_REG = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        RegWrite,
    input  logic [4:0]  addr,
    output logic [31:0] wr_en,
    output logic [3:0]  grp_en
);
    localparam int NUM_GRP = 4;
    localparam int GRP_W   = 8;

    logic [NUM_GRP-1:0]            grp_en_d;
    logic [NUM_GRP-1:0][GRP_W-1:0] leaf_dec;
    logic [31:0]                   wr_en_d;

    // 2:4 stage; RegWrite low forces zero regardless of addr.
    always_comb begin
        grp_en_d = '0;
        if (RegWrite) begin
            for (int g = 0; g < NUM_GRP; g++) begin
                grp_en_d[g] = (addr[4:3] == 2'(g));
            end
        end
    end

    // 3:8 leaves, one per group.
    for (genvar g = 0; g < NUM_GRP; g++) begin : g_leaf
        regfile_wr_dec3to8 u_leaf (
            .en_i  (grp_en_d[g]),
            .sel_i (addr[2:0]),
            .dec_o (leaf_dec[g])
        );
    end

`ifdef XZR_MASK_EN
    // XZR is a discard target: keep its group enable but drop the bit.
    always_comb begin
        wr_en_d     = leaf_dec;
        wr_en_d[31] = 1'b0;
    end
`else
    assign wr_en_d = leaf_dec;
`endif

    if (OUT_REG) begin : g_oreg
        logic [31:0] wr_en_q;
        logic [3:0]  grp_en_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wr_en_q  <= '0;
                grp_en_q <= '0;
            end else begin
                wr_en_q  <= wr_en_d;
                grp_en_q <= grp_en_d;
            end
        end

        assign wr_en  = wr_en_q;
        assign grp_en = grp_en_q;
    end else begin : g_comb
        assign wr_en  = wr_en_d;
        assign grp_en = grp_en_d;
    end
endmodule

// File: tb/tb_regfile_wr_decoder.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_decoder
//   Directed bench for regfile_wr_decoder with OUT_REG = 1. Inputs change on
//   the falling edge; outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_regfile_wr_decoder;
    logic        clk;
    logic        reset_n;
    logic        RegWrite;
    logic [4:0]  addr;
    logic [31:0] wr_en;
    logic [3:0]  grp_en;

    int n_chk;
    int n_fail;

    regfile_wr_decoder #(.OUT_REG(1'b1)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .RegWrite (RegWrite),
        .addr     (addr),
        .wr_en    (wr_en),
        .grp_en   (grp_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present inputs on the falling edge, then sample after the next rising edge.
    task automatic apply(input logic rw, input logic [4:0] a);
        @(negedge clk);
        RegWrite = rw;
        addr     = a;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_wr(input logic rw, input logic [4:0] a);
        logic [31:0] v;
        v = rw ? (32'h1 << a) : 32'h0;
`ifdef XZR_MASK_EN
        v[31] = 1'b0;
`endif
        return v;
    endfunction

    function automatic logic [31:0] exp_grp(input logic rw, input logic [4:0] a);
        return rw ? (32'h1 << a[4:3]) : 32'h0;
    endfunction

    initial begin
        logic [4:0]  a;
        logic [31:0] ew;
        n_chk    = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        RegWrite = 1'b1;
        addr     = 5'd5;

        // Held in reset: outputs stay zero across clock edges.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_wr", wr_en, 32'h0);
        chk("rst_hold_grp", {28'h0, grp_en}, 32'h0);

        // First edge after release reflects the inputs then present.
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rel_wr", wr_en, 32'h0000_0020);
        chk("rst_rel_grp", {28'h0, grp_en}, 32'h1);

        // Asynchronous reset mid-cycle clears outputs without an edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_wr", wr_en, 32'h0);
        chk("rst_async_grp", {28'h0, grp_en}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_low_wr", wr_en, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Gating.
        apply(1'b0, 5'd4);
        chk("gate_wr", wr_en, 32'h0);
        chk("gate_grp", {28'h0, grp_en}, 32'h0);

        // RegWrite low masks an unknown address.
        apply(1'b0, 5'bxxxxx);
        chk("gate_x_wr", wr_en, 32'h0);
        chk("gate_x_grp", {28'h0, grp_en}, 32'h0);

        // Group edges.
        apply(1'b1, 5'd7);
        chk("edge7_wr", wr_en, 32'h0000_0080);
        chk("edge7_grp", {28'h0, grp_en}, 32'h1);
        apply(1'b1, 5'd8);
        chk("edge8_wr", wr_en, 32'h0000_0100);
        chk("edge8_grp", {28'h0, grp_en}, 32'h2);
        apply(1'b1, 5'd0);
        chk("addr0_wr", wr_en, 32'h0000_0001);
        chk("addr0_grp", {28'h0, grp_en}, 32'h1);

        // Top entry.
        apply(1'b1, 5'd31);
`ifdef XZR_MASK_EN
        chk("addr31_wr", wr_en, 32'h0);
`else
        chk("addr31_wr", wr_en, 32'h8000_0000);
`endif
        chk("addr31_grp", {28'h0, grp_en}, 32'h8);

        // Triangular sweep with 5-bit wrap: 0, 1, 3, 6, 10, 15, 21, 28, 4, ...
        a = 5'd0;
        for (int i = 0; i < 32; i++) begin
            a = a + 5'(i);
            apply(1'b1, a);
            ew = exp_wr(1'b1, a);
            chk($sformatf("sweep_wr[%0d]", a), wr_en, ew);
            chk($sformatf("sweep_1hot[%0d]", a), {31'h0, $onehot(wr_en)}, {31'h0, (ew != 32'h0)});
            chk($sformatf("sweep_grp[%0d]", a), {28'h0, grp_en}, exp_grp(1'b1, a));
        end

        // Latency: one cycle from input change to output.
        apply(1'b1, 5'd3);
        chk("lat_pre", wr_en, 32'h0000_0008);
        @(negedge clk);
        addr = 5'd9;
        #1;
        chk("lat_hold", wr_en, 32'h0000_0008);
        @(posedge clk);
        #1;
        chk("lat_post_wr", wr_en, 32'h0000_0200);
        chk("lat_post_grp", {28'h0, grp_en}, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
